// File: rtl/mure_pkg.sv
// mure_pkg: shared types and widths for the CVA6->TE connector read side.
//   itype_e        instruction type as seen by the trace encoder
//   uop_entry_s    uop FIFO entry
//   common_entry_s common FIFO entry (trap info + privilege)
//   reader_state_e reader FSM states
//   te_entry_s     merged record presented to the trace encoder
package mure_pkg;
    localparam int ITYPE_LEN     = 3;
    localparam int INST_LEN      = 32;
    localparam int XLEN          = 32;
    localparam int CAUSE_LEN     = 5;
    localparam int PRIV_LEN      = 2;
    localparam int ILASTSIZE_LEN = 1;

    typedef enum logic [ITYPE_LEN-1:0] {
        STD = 3'd0, EXC = 3'd1, INT = 3'd2, ERET = 3'd3,
        NTB = 3'd4, TB = 3'd5, UIJ = 3'd6, UJ = 3'd7
    } itype_e;

    typedef struct packed {
        itype_e                   itype;
        logic [INST_LEN-1:0]      iaddr;
        logic                     iretire;
        logic [ILASTSIZE_LEN-1:0] ilastsize;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } common_entry_s;

    typedef enum logic [1:0] {EMPTY, FULL, WAIT_CMN} reader_state_e;

    typedef struct packed {
        itype_e                   itype;
        logic [INST_LEN-1:0]      iaddr;
        logic                     iretire;
        logic [ILASTSIZE_LEN-1:0] ilastsize;
        logic [CAUSE_LEN-1:0]     cause;
        logic [XLEN-1:0]          tval;
        logic [PRIV_LEN-1:0]      priv;
    } te_entry_s;

    localparam te_entry_s TE_RST = '{itype: STD, iaddr: '0, iretire: 1'b0, ilastsize: '0,
                                     cause: '0, tval: '0, priv: 2'b11};

    function automatic logic needs_cmn(itype_e t);
        return t inside {EXC, INT, ERET};
    endfunction
endpackage

// File: rtl/mure_te_reader.sv
// mure_te_reader: pops uop (+ common for EXC/INT/ERET) entries, presents merged TE record.
//   clk_i/rst_i          clock, synchronous active-high reset
//   flush_i              drop output record, return to EMPTY
//   uop_*                uop FIFO head/empty/pop
//   cmn_*                common FIFO head/empty/pop
//   valid_o/ready_i      registered valid/ready handshake to the TE
//   itype_o..priv_o      merged record fields
//   cmn_wait_o           uop at head is waiting for its common entry
//   stall_cnt_o          saturating stall counter (only with MURE_STALL_CNT_EN)
module mure_te_reader
    import mure_pkg::*;
`ifdef MURE_STALL_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     uop_empty_i,
    input  uop_entry_s               uop_data_i,
    output logic                     uop_pop_o,
    input  logic                     cmn_empty_i,
    input  common_entry_s            cmn_data_i,
    output logic                     cmn_pop_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [ITYPE_LEN-1:0]     itype_o,
    output logic [INST_LEN-1:0]      iaddr_o,
    output logic                     iretire_o,
    output logic [ILASTSIZE_LEN-1:0] ilastsize_o,
    output logic [CAUSE_LEN-1:0]     cause_o,
    output logic [XLEN-1:0]          tval_o,
    output logic [PRIV_LEN-1:0]      priv_o,
    output logic                     cmn_wait_o
`ifdef MURE_STALL_CNT_EN
   ,output logic [CNT_W-1:0]         stall_cnt_o
`endif
);
    reader_state_e state, state_nxt;
    te_entry_s     rec, rec_nxt;
    logic          cmn, trap, slot_free, take;

    always_comb begin
        cmn       = needs_cmn(uop_data_i.itype);
        trap      = uop_data_i.itype inside {EXC, INT};
        slot_free = (state != FULL) | ready_i;
        take      = slot_free & !uop_empty_i & !flush_i & (!cmn | !cmn_empty_i);
        // a stalled FULL holds; otherwise a blocked cmn-uop parks in WAIT_CMN
        state_nxt = flush_i ? EMPTY :
                    take ? FULL :
                    !slot_free ? FULL :
                    (!uop_empty_i & cmn) ? WAIT_CMN : EMPTY;
        rec_nxt = rec;
        if (take) begin
            rec_nxt.itype     = uop_data_i.itype;
            rec_nxt.iaddr     = uop_data_i.iaddr;
            rec_nxt.iretire   = uop_data_i.iretire;
            rec_nxt.ilastsize = uop_data_i.ilastsize;
            rec_nxt.cause     = trap ? cmn_data_i.cause : '0;
            rec_nxt.tval      = trap ? cmn_data_i.tval : '0;
            rec_nxt.priv      = cmn ? cmn_data_i.priv : rec.priv;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
            rec   <= TE_RST;
        end else begin
            state <= state_nxt;
            rec   <= rec_nxt;
        end
    end

`ifdef MURE_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if ((((state == FULL) & !ready_i) | (state == WAIT_CMN)) & ~&stall_cnt_o)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
`endif

    assign uop_pop_o   = take;
    assign cmn_pop_o   = take & cmn;
    assign valid_o     = state == FULL;
    assign cmn_wait_o  = state == WAIT_CMN;
    assign itype_o     = rec.itype;
    assign iaddr_o     = rec.iaddr;
    assign iretire_o   = rec.iretire;
    assign ilastsize_o = rec.ilastsize;
    assign cause_o     = rec.cause;
    assign tval_o      = rec.tval;
    assign priv_o      = rec.priv;
endmodule
